// File: rtl/reset_gen.sv
// Reset request generator: merges board reset, debounced pushbutton and software
// request into one registered, minimum-width active-high reset request.
module reset_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 32,
    parameter int POR_CYCLES      = 64,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       preset_n,
    input  logic       btn_n,
    input  logic       sw_req,
    output logic       preset_out,
    output logic [1:0] reset_cause,
    output logic [7:0] reset_count
);

    // state    | meaning
    // ST_POR   | power-on hold, counting POR_CYCLES after preset_n release
    // ST_HOLD  | warm reset hold, counting HOLD_CYCLES
    // ST_WAIT  | hold expired with button still pressed, wait for release
    // ST_RUN   | reset released, watching button and software request
    typedef enum logic [1:0] {
        ST_POR  = 2'd0,
        ST_HOLD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam logic [1:0]       CAUSE_POR = 2'b01;
    localparam logic [1:0]       CAUSE_BTN = 2'b10;
    localparam logic [1:0]       CAUSE_SW  = 2'b11;
    localparam logic [CNT_W-1:0] POR_LOAD  = CNT_W'(POR_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    logic                   deb;
    logic [CNT_W-1:0]       deb_cnt;
    state_t                 state, next_state;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic [1:0]             cause_next;
    logic                   hold_entry;

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ~btn_n};
        end
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

    // deb toggles on the sample that brings the mismatch run up to DEBOUNCE_CYCLES
    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else if (btn_s == deb) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb     <= ~deb;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        cause_next = reset_cause;
        hold_entry = 1'b0;
        case (state)
            ST_POR, ST_HOLD: begin
                if (cnt <= CNT_ONE) begin
                    next_state = deb ? ST_WAIT : ST_RUN;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_WAIT: begin
                if (!deb) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                // RUN is only entered with deb low, so deb high here is a fresh press
                if (deb) begin
                    next_state = ST_HOLD;
                    cnt_next   = HOLD_LOAD;
                    cause_next = CAUSE_BTN;
                    hold_entry = 1'b1;
                end else if (sw_req) begin
                    next_state = ST_HOLD;
                    cnt_next   = HOLD_LOAD;
                    cause_next = CAUSE_SW;
                    hold_entry = 1'b1;
                end
            end
            default: begin
                next_state = ST_POR;
                cnt_next   = POR_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            state       <= ST_POR;
            cnt         <= POR_LOAD;
            preset_out  <= 1'b1;
            reset_cause <= CAUSE_POR;
            reset_count <= '0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_next;
            preset_out  <= (next_state != ST_RUN);
            reset_cause <= cause_next;
            if (hold_entry && (reset_count != 8'hFF)) begin
                reset_count <= reset_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reset_gen.sv
// Scoreboard bench for reset_gen: expectations are queued as stimulus is driven
// and popped against observed pulse timings, cause and count.
module tb_reset_gen;

    logic       clk = 1'b0;
    logic       preset_n;
    logic       btn_n;
    logic       sw_req;
    logic       preset_out;
    logic [1:0] reset_cause;
    logic [7:0] reset_count;

    typedef struct {
        string name;
        int    value;
        int    tol;
    } exp_t;

    exp_t sb[$];
    int   obs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    reset_gen #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(16),
        .HOLD_CYCLES    (32),
        .POR_CYCLES     (64),
        .CNT_W          (16)
    ) dut (
        .clk        (clk),
        .preset_n   (preset_n),
        .btn_n      (btn_n),
        .sw_req     (sw_req),
        .preset_out (preset_out),
        .reset_cause(reset_cause),
        .reset_count(reset_count)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "global timeout");
    end

    function automatic void push_exp(input string name, input int value, input int tol);
        exp_t e;
        e.name  = name;
        e.value = value;
        e.tol   = tol;
        sb.push_back(e);
    endfunction

    // Counts falling edges until preset_out reaches lvl; -1 when the budget runs out.
    task automatic wait_preset(input logic lvl, input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (preset_out !== lvl && n < max_cyc);
        if (preset_out !== lvl) n = -1;
    endtask

    task automatic test_reset();
        int   n;
        exp_t e;
        int   o;
        push_exp("rst_preset", 1, 0);
        push_exp("rst_cause", 1, 0);
        push_exp("rst_count", 0, 0);
        push_exp("por_width", 64, 0);
        push_exp("por_cause", 1, 0);
        push_exp("por_count", 0, 0);
        preset_n = 1'b0;
        btn_n    = 1'b1;
        sw_req   = 1'b0;
        repeat (5) @(negedge clk);
        obs.push_back(int'(preset_out));
        obs.push_back(int'(reset_cause));
        obs.push_back(int'(reset_count));
        preset_n = 1'b1;
        wait_preset(1'b0, 200, n);
        obs.push_back(n);
        obs.push_back(int'(reset_cause));
        obs.push_back(int'(reset_count));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs.size() > 0) ? obs.pop_front() : -999;
            n_cmp++;
            if (o < e.value - e.tol || o > e.value + e.tol) begin
                n_bad++;
                $display("FAIL %s: observed %0d, expected %0d (+/-%0d)", e.name, o, e.value, e.tol);
            end
        end
    endtask

    task automatic test_bounce();
        int   seen;
        exp_t e;
        int   o;
        push_exp("bounce_preset_seen", 0, 0);
        push_exp("bounce_count", 0, 0);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            btn_n = ((i / 10) % 2 == 1);
            @(negedge clk);
            if (preset_out !== 1'b0) seen = 1;
        end
        btn_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (preset_out !== 1'b0) seen = 1;
        end
        obs.push_back(seen);
        obs.push_back(int'(reset_count));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs.size() > 0) ? obs.pop_front() : -999;
            n_cmp++;
            if (o < e.value - e.tol || o > e.value + e.tol) begin
                n_bad++;
                $display("FAIL %s: observed %0d, expected %0d (+/-%0d)", e.name, o, e.value, e.tol);
            end
        end
    endtask

    task automatic test_button();
        int   n;
        int   gaps;
        exp_t e;
        int   o;
        push_exp("btn_rise_delay", 19, 1);
        push_exp("btn_held_gaps", 0, 0);
        push_exp("btn_fall_delay", 19, 1);
        push_exp("btn_cause", 2, 0);
        push_exp("btn_count", 1, 0);
        btn_n = 1'b0;
        wait_preset(1'b1, 60, n);
        obs.push_back(n);
        gaps = 0;
        for (int i = (n < 0 ? 60 : n); i < 100; i++) begin
            @(negedge clk);
            if (preset_out !== 1'b1) gaps++;
        end
        obs.push_back(gaps);
        btn_n = 1'b1;
        wait_preset(1'b0, 60, n);
        obs.push_back(n);
        obs.push_back(int'(reset_cause));
        obs.push_back(int'(reset_count));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs.size() > 0) ? obs.pop_front() : -999;
            n_cmp++;
            if (o < e.value - e.tol || o > e.value + e.tol) begin
                n_bad++;
                $display("FAIL %s: observed %0d, expected %0d (+/-%0d)", e.name, o, e.value, e.tol);
            end
        end
    endtask

    task automatic test_sw();
        int   w;
        int   i;
        exp_t e;
        int   o;
        push_exp("sw_latency_preset", 1, 0);
        push_exp("sw_width", 32, 0);
        push_exp("sw_cause", 3, 0);
        push_exp("sw_count", 2, 0);
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        obs.push_back(int'(preset_out));
        w = 0;
        i = 0;
        while (preset_out === 1'b1 && i < 100) begin
            w++;
            sw_req = (i == 10);
            @(negedge clk);
            i++;
        end
        sw_req = 1'b0;
        obs.push_back(w);
        obs.push_back(int'(reset_cause));
        obs.push_back(int'(reset_count));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs.size() > 0) ? obs.pop_front() : -999;
            n_cmp++;
            if (o < e.value - e.tol || o > e.value + e.tol) begin
                n_bad++;
                $display("FAIL %s: observed %0d, expected %0d (+/-%0d)", e.name, o, e.value, e.tol);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   w;
        int   i;
        int   n;
        int   tmo;
        int   mid;
        exp_t e;
        int   o;
        push_exp("b2b_width", 32, 0);
        push_exp("b2b_cause", 2, 0);
        push_exp("b2b_count", 3, 0);
        push_exp("sat_mid_count", 103, 0);
        push_exp("sat_timeouts", 0, 0);
        push_exp("sat_count", 255, 0);
        push_exp("sat_cause", 3, 0);
        // deb rises at edge 18 after the press, so the FSM sees it with sw_req at edge 19
        btn_n = 1'b0;
        repeat (18) @(negedge clk);
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        btn_n  = 1'b1;
        w = 0;
        i = 0;
        while (preset_out === 1'b1 && i < 100) begin
            w++;
            @(negedge clk);
            i++;
        end
        obs.push_back(w);
        obs.push_back(int'(reset_cause));
        obs.push_back(int'(reset_count));
        tmo = 0;
        mid = -1;
        for (int k = 0; k < 300; k++) begin
            sw_req = 1'b1;
            @(negedge clk);
            sw_req = 1'b0;
            wait_preset(1'b0, 100, n);
            if (n < 0) tmo++;
            if (k == 99) mid = int'(reset_count);
        end
        obs.push_back(mid);
        obs.push_back(tmo);
        obs.push_back(int'(reset_count));
        obs.push_back(int'(reset_cause));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs.size() > 0) ? obs.pop_front() : -999;
            n_cmp++;
            if (o < e.value - e.tol || o > e.value + e.tol) begin
                n_bad++;
                $display("FAIL %s: observed %0d, expected %0d (+/-%0d)", e.name, o, e.value, e.tol);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int   n;
        int   low_seen;
        exp_t e;
        int   o;
        push_exp("mid_hold_preset", 1, 0);
        push_exp("mid_rst_preset", 1, 0);
        push_exp("mid_rst_cause", 1, 0);
        push_exp("mid_rst_count", 0, 0);
        push_exp("mid_rst_low_seen", 0, 0);
        push_exp("mid_por_width", 64, 0);
        push_exp("mid_por_cause", 1, 0);
        push_exp("mid_por_count", 0, 0);
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        repeat (9) @(negedge clk);
        obs.push_back(int'(preset_out));
        preset_n = 1'b0;
        #1;
        obs.push_back(int'(preset_out));
        obs.push_back(int'(reset_cause));
        obs.push_back(int'(reset_count));
        low_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (preset_out !== 1'b1) low_seen = 1;
        end
        preset_n = 1'b1;
        obs.push_back(low_seen);
        wait_preset(1'b0, 200, n);
        obs.push_back(n);
        obs.push_back(int'(reset_cause));
        obs.push_back(int'(reset_count));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs.size() > 0) ? obs.pop_front() : -999;
            n_cmp++;
            if (o < e.value - e.tol || o > e.value + e.tol) begin
                n_bad++;
                $display("FAIL %s: observed %0d, expected %0d (+/-%0d)", e.name, o, e.value, e.tol);
            end
        end
    endtask

    initial begin
        preset_n = 1'b0;
        btn_n    = 1'b1;
        sw_req   = 1'b0;
        test_reset();
        test_bounce();
        test_button();
        test_sw();
        test_back_to_back();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
